obc_answer_responder: RTL and testbench

//  OBC-side responder of the error-checking watchdog protocol. Captures each 4-bit question

---
 rtl/error_checking_pkg.sv | 26 ++
 rtl/obc_answer_responder.sv | 135 +++++++++++++
 tb/tb_obc_answer_responder.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/error_checking_pkg.sv
// Shared definitions for the error-checking watchdog protocol: the question
// width, the responder FSM encodings and the fixed question->answer transform
// that both the OBC responder and the supervisor-side checker use.
package error_checking_pkg;

  // Width of a supervisor question and of the matching answer.
  localparam int QUESTION_W = 4;

  // Responder FSM encodings (kept as plain constants so legacy tools and the
  // supervisor checker can compare raw state values).
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_WAIT    = 2'd1;
  localparam logic [1:0] ST_PRESENT = 2'd2;

  // Fixed transform: bit 0 is the inverted LSB, every higher bit is the XOR of
  // the question bit and its lower neighbour.
  function automatic logic [QUESTION_W-1:0] obc_answer(input logic [QUESTION_W-1:0] q);
    logic [QUESTION_W-1:0] a;
    a[0] = ~q[0];
    for (int i = 1; i < QUESTION_W; i++) begin
      a[i] = q[i] ^ q[i-1];
    end
    return a;
  endfunction

endpackage

// File: rtl/obc_answer_responder.sv
// OBC-side responder of the watchdog protocol. Captures a question, waits a
// programmable delay, then presents the transformed answer until the
// supervisor acknowledges it or the ack window expires. Questions arriving
// while an exchange is in flight are dropped and flagged as overruns.
module obc_answer_responder
  import error_checking_pkg::*;
#(
  parameter int RESP_DELAY  = 2,
  parameter int ACK_TIMEOUT = 8,
  parameter int CNT_W       = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  question_valid,
  input  logic [QUESTION_W-1:0] question,
  input  logic                  answer_ack,
  input  logic                  inject_fault,
  output logic [QUESTION_W-1:0] answer,
  output logic                  answer_valid,
  output logic                  busy,
  output logic [CNT_W-1:0]      answered_cnt,
  output logic                  timeout_err,
  output logic                  overrun
);

  // Delay counter holds RESP_DELAY (0..15); ack counter must reach ACK_TIMEOUT-1.
  localparam int DELAY_W = 4;
  localparam int ACK_W   = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

  localparam logic [DELAY_W-1:0] DELAY_LOAD = DELAY_W'(RESP_DELAY);
  localparam logic [ACK_W-1:0]   ACK_LAST   = ACK_W'(ACK_TIMEOUT - 1);
  localparam logic [1:0]         ST_AFTER_CAPTURE = (RESP_DELAY == 0) ? ST_PRESENT : ST_WAIT;

  logic [1:0]            state_q,     state_d;
  logic [DELAY_W-1:0]    delay_cnt_q, delay_cnt_d;
  logic [ACK_W-1:0]      ack_cnt_q,   ack_cnt_d;
  logic [QUESTION_W-1:0] answer_q,    answer_d;
  logic [CNT_W-1:0]      cnt_q,       cnt_d;
  logic                  timeout_q,   timeout_d;
  logic                  overrun_q,   overrun_d;

  // Next-state logic for the FSM, counters and registered outputs.
  always_comb begin
    state_d     = state_q;
    delay_cnt_d = delay_cnt_q;
    ack_cnt_d   = ack_cnt_q;
    answer_d    = answer_q;
    cnt_d       = cnt_q;
    timeout_d   = 1'b0;
    // Any question seen while not idle is dropped, including on the exit edge,
    // so a new exchange can never start back-to-back with the previous one.
    overrun_d   = question_valid && (state_q != ST_IDLE);

    case (state_q)
      ST_IDLE: begin
        ack_cnt_d = '0;
        if (enable && question_valid) begin
          // Fault injection flips only bit 0 so the supervisor sees a mismatch.
          answer_d    = obc_answer(question) ^ QUESTION_W'(inject_fault);
          delay_cnt_d = DELAY_LOAD;
          state_d     = ST_AFTER_CAPTURE;
        end
      end

      ST_WAIT: begin
        if (!enable) begin
          state_d     = ST_IDLE;
          delay_cnt_d = '0;
        end else begin
          // Leaving at 1 (not 0) makes valid rise RESP_DELAY+1 edges after capture.
          delay_cnt_d = delay_cnt_q - 1'b1;
          if (delay_cnt_q <= 4'd1) begin
            state_d   = ST_PRESENT;
            ack_cnt_d = '0;
          end
        end
      end

      ST_PRESENT: begin
        if (!enable) begin
          // Silent abort: no count, no error pulse.
          state_d   = ST_IDLE;
          ack_cnt_d = '0;
        end else if (answer_ack) begin
          // Ack wins over a timeout falling on the same edge.
          state_d   = ST_IDLE;
          ack_cnt_d = '0;
          cnt_d     = cnt_q + 1'b1;
        end else if (ack_cnt_q == ACK_LAST) begin
          state_d   = ST_IDLE;
          ack_cnt_d = '0;
          timeout_d = 1'b1;
        end else begin
          ack_cnt_d = ack_cnt_q + 1'b1;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        delay_cnt_d = '0;
        ack_cnt_d   = '0;
      end
    endcase
  end

  // State and output registers; reset clears everything without emitting pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      delay_cnt_q <= '0;
      ack_cnt_q   <= '0;
      answer_q    <= '0;
      cnt_q       <= '0;
      timeout_q   <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      delay_cnt_q <= delay_cnt_d;
      ack_cnt_q   <= ack_cnt_d;
      answer_q    <= answer_d;
      cnt_q       <= cnt_d;
      timeout_q   <= timeout_d;
      overrun_q   <= overrun_d;
    end
  end

  assign answer       = answer_q;
  assign answer_valid = (state_q == ST_PRESENT);
  assign busy         = (state_q != ST_IDLE);
  assign answered_cnt = cnt_q;
  assign timeout_err  = timeout_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_obc_answer_responder.sv
// Directed bench for obc_answer_responder: latency, transform table, fault
// injection, ack timeout, overrun, enable abort and asynchronous reset.
module tb_obc_answer_responder;

  localparam int RESP_DELAY  = 2;
  localparam int ACK_TIMEOUT = 8;
  localparam int CNT_W       = 8;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             enable = 1'b0;
  logic             question_valid = 1'b0;
  logic [3:0]       question = '0;
  logic             answer_ack = 1'b0;
  logic             inject_fault = 1'b0;
  logic [3:0]       answer;
  logic             answer_valid;
  logic             busy;
  logic [CNT_W-1:0] answered_cnt;
  logic             timeout_err;
  logic             overrun;

  int n_checks = 0;
  int n_errors = 0;

  // Hand-computed answers for questions 0..15.
  logic [3:0] exp_tab [16] = '{4'h1, 4'h2, 4'h7, 4'h4, 4'hD, 4'hE, 4'hB, 4'h8,
                               4'h9, 4'hA, 4'hF, 4'hC, 4'h5, 4'h6, 4'h3, 4'h0};

  obc_answer_responder #(
    .RESP_DELAY (RESP_DELAY),
    .ACK_TIMEOUT(ACK_TIMEOUT),
    .CNT_W      (CNT_W)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .question_valid(question_valid),
    .question      (question),
    .answer_ack    (answer_ack),
    .inject_fault  (inject_fault),
    .answer        (answer),
    .answer_valid  (answer_valid),
    .busy          (busy),
    .answered_cnt  (answered_cnt),
    .timeout_err   (timeout_err),
    .overrun       (overrun)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end else begin
      $display("ok   %s: %0d", tag, obs);
    end
  endtask

  // Issue one question, wait (bounded) for the answer; returns edges counted
  // from capture until answer_valid is seen.
  task automatic ask(input logic [3:0] q, input logic fault, output int n);
    question       = q;
    inject_fault   = fault;
    question_valid = 1'b1;
    @(negedge clk);
    question_valid = 1'b0;
    inject_fault   = 1'b0;
    n = 1;
    while (!answer_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  // Full acked exchange with latency and answer checks.
  task automatic exchange(input logic [3:0] q, input logic fault, input logic [3:0] exp, input string tag);
    int n;
    ask(q, fault, n);
    check_eq({tag, "_latency"}, n, RESP_DELAY + 1);
    check_eq({tag, "_answer"}, int'(answer), int'(exp));
    answer_ack = 1'b1;
    @(negedge clk);
    answer_ack = 1'b0;
    check_eq({tag, "_valid_drop"}, int'(answer_valid), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int n;

    // Reset state
    @(negedge clk);
    check_eq("rst_valid", int'(answer_valid), 0);
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_answer", int'(answer), 0);
    check_eq("rst_cnt", int'(answered_cnt), 0);
    check_eq("rst_flags", int'({timeout_err, overrun}), 0);
    reset  = 1'b1;
    enable = 1'b1;
    @(negedge clk);

    // 1: basic exchange, valid visible 3 edges after capture
    question = 4'b0000;
    question_valid = 1'b1;
    @(negedge clk);
    question_valid = 1'b0;
    check_eq("t1_wait_busy", int'(busy), 1);
    check_eq("t1_wait_valid0", int'(answer_valid), 0);
    @(negedge clk);
    check_eq("t1_wait_valid1", int'(answer_valid), 0);
    @(negedge clk);
    check_eq("t1_valid", int'(answer_valid), 1);
    check_eq("t1_answer", int'(answer), 1);
    answer_ack = 1'b1;
    @(negedge clk);
    answer_ack = 1'b0;
    check_eq("t1_cnt", int'(answered_cnt), 1);
    check_eq("t1_idle", int'(busy), 0);

    // Ack while idle is ignored
    answer_ack = 1'b1;
    repeat (2) @(negedge clk);
    answer_ack = 1'b0;
    check_eq("idle_ack_cnt", int'(answered_cnt), 1);

    // 2: transform sweep (count continues from 1)
    for (int i = 0; i < 16; i++) begin
      exchange(4'(i), 1'b0, exp_tab[i], $sformatf("sweep_q%0d", i));
    end
    check_eq("sweep_cnt", int'(answered_cnt), 17);

    // 3: fault injection flips bit 0
    exchange(4'b0000, 1'b1, 4'b0000, "fault");
    check_eq("fault_cnt", int'(answered_cnt), 18);

    // 4: no ack -> valid for ACK_TIMEOUT cycles then timeout pulse
    ask(4'b0101, 1'b0, n);
    check_eq("to_latency", n, RESP_DELAY + 1);
    n = 0;
    while (answer_valid && n < 30) begin
      n++;
      @(negedge clk);
    end
    check_eq("to_valid_cycles", n, ACK_TIMEOUT);
    check_eq("to_pulse", int'(timeout_err), 1);
    @(negedge clk);
    check_eq("to_pulse_end", int'(timeout_err), 0);
    check_eq("to_cnt", int'(answered_cnt), 18);

    // 5: overrun during WAIT, then enable=0 in PRESENT
    question = 4'b0011;
    question_valid = 1'b1;
    @(negedge clk);
    question = 4'b1111;
    @(negedge clk);
    question_valid = 1'b0;
    check_eq("ovr_pulse", int'(overrun), 1);
    @(negedge clk);
    check_eq("ovr_pulse_end", int'(overrun), 0);
    check_eq("ovr_valid", int'(answer_valid), 1);
    check_eq("ovr_answer", int'(answer), 4);
    enable = 1'b0;
    @(negedge clk);
    check_eq("dis_valid", int'(answer_valid), 0);
    check_eq("dis_busy", int'(busy), 0);
    check_eq("dis_noerr", int'(timeout_err), 0);
    check_eq("dis_cnt", int'(answered_cnt), 18);
    enable = 1'b1;
    @(negedge clk);

    // 5b: question on the ack (exit) edge is an overrun, not a capture
    ask(4'b0110, 1'b0, n);
    check_eq("exit_latency", n, RESP_DELAY + 1);
    answer_ack = 1'b1;
    question = 4'b0001;
    question_valid = 1'b1;
    @(negedge clk);
    answer_ack = 1'b0;
    question_valid = 1'b0;
    check_eq("exit_ovr", int'(overrun), 1);
    check_eq("exit_busy", int'(busy), 0);
    check_eq("exit_cnt", int'(answered_cnt), 19);
    @(negedge clk);
    check_eq("exit_still_idle", int'(busy), 0);

    // 6: asynchronous reset while presenting
    ask(4'b1010, 1'b0, n);
    check_eq("ar_valid", int'(answer_valid), 1);
    #2 reset = 1'b0;
    #1;
    check_eq("ar_valid0", int'(answer_valid), 0);
    check_eq("ar_busy0", int'(busy), 0);
    check_eq("ar_answer0", int'(answer), 0);
    check_eq("ar_cnt0", int'(answered_cnt), 0);
    check_eq("ar_flags0", int'({timeout_err, overrun}), 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    exchange(4'b1011, 1'b0, 4'b1100, "post_rst");
    check_eq("post_rst_cnt", int'(answered_cnt), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
